// File: rtl/bj_pkg.sv
// bj_pkg: shared types and constants for the blackjack game controller.
//   - bj_state_e : controller FSM states
//   - bj_who_e   : which hand receives the next accepted card
//   - RANK_*     : 4-bit rank codes carried in iCard[5:2]
//   - BJ_BUST    : highest non-bust hand value
//   - rank_value : rank code -> card value (0 marks an invalid rank)
package bj_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DRAW,
        ST_EVAL,
        ST_PLAYER,
        ST_DEALER,
        ST_DONE
    } bj_state_e;

    typedef enum logic {
        WHO_PLAYER,
        WHO_DEALER
    } bj_who_e;

    localparam logic [3:0] RANK_ACE   = 4'b0000;
    localparam logic [3:0] RANK_TWO   = 4'b0010;
    localparam logic [3:0] RANK_NINE  = 4'b1001;
    localparam logic [3:0] RANK_TEN   = 4'b1100;
    localparam logic [3:0] RANK_JACK  = 4'b1101;
    localparam logic [3:0] RANK_QUEEN = 4'b1110;
    localparam logic [3:0] RANK_KING  = 4'b1111;

    localparam logic [4:0] BJ_BUST = 5'd21;

    // No real card is worth 0, so a 0 result doubles as the invalid-rank flag
    // (codes 0001, 1010 and 1011).
    function automatic logic [3:0] rank_value(input logic [3:0] rank);
        logic [3:0] v;
        case (rank)
            RANK_ACE:                               v = 4'd1;
            RANK_TEN, RANK_JACK, RANK_QUEEN, RANK_KING: v = 4'd10;
            4'b0001, 4'b1010, 4'b1011:              v = 4'd0;
            default:                                v = rank; // 2..9 encode their own value
        endcase
        return v;
    endfunction

endpackage

// File: rtl/blackjack_game_ctrl_if.sv
// blackjack_game_ctrl_if: card handshake between the game controller and the shuffler.
//   iCard      [5:0] card from shuffler; [5:2] rank code, [1:0] suit
//   iCardValid       iCard is valid this cycle
//   oCardReq         controller wants a card
// Handshake: a card is taken on a rising clk edge where oCardReq=1 and
// iCardValid=1 and the rank is valid; a card offered while oCardReq=0 is
// ignored, and an invalid rank is dropped with oCardReq left high.
// Modports: master = game controller, slave = shuffler.
interface blackjack_game_ctrl_if;
    logic [5:0] iCard;
    logic       iCardValid;
    logic       oCardReq;

    modport master (input iCard, input iCardValid, output oCardReq);
    modport slave  (output iCard, output iCardValid, input oCardReq);
endinterface

// File: rtl/bj_hand.sv
// bj_hand: one blackjack hand (used for both player and dealer).
//   clk, iRST_N : clock, asynchronous active-low reset
//   clear       : empty the hand (wins over add)
//   add         : add the card whose rank is on 'rank' (rank must be valid)
//   rank  [3:0] : rank code of the card being added
//   value [4:0] : hand value
// Hard total saturates at 31. With BJ_SOFT_ACE_EN defined an ace flag is
// kept and one ace counts 11 while that does not push the hand past 21.
module bj_hand
    import bj_pkg::*;
(
    input  logic       clk,
    input  logic       iRST_N,
    input  logic       clear,
    input  logic       add,
    input  logic [3:0] rank,
    output logic [4:0] value
);

    logic [4:0] hard_q, hard_d;
    logic [5:0] sum;

    always_comb begin
        sum    = {1'b0, hard_q} + {2'b00, rank_value(rank)};
        hard_d = hard_q;
        if (clear)    hard_d = '0;
        else if (add) hard_d = sum[5] ? 5'd31 : sum[4:0];
    end

    always_ff @(posedge clk or negedge iRST_N) begin
        if (!iRST_N) hard_q <= '0;
        else         hard_q <= hard_d;
    end

`ifdef BJ_SOFT_ACE_EN
    logic ace_q, ace_d;

    always_comb begin
        ace_d = ace_q;
        if (clear)                          ace_d = 1'b0;
        else if (add && rank == RANK_ACE)   ace_d = 1'b1;
    end

    always_ff @(posedge clk or negedge iRST_N) begin
        if (!iRST_N) ace_q <= 1'b0;
        else         ace_q <= ace_d;
    end

    assign value = (ace_q && hard_q <= 5'd11) ? hard_q + 5'd10 : hard_q;
`else
    assign value = hard_q;
`endif

endmodule

// File: rtl/blackjack_game_ctrl.sv
// blackjack_game_ctrl: blackjack round sequencer feeding the LCD display stage.
//   clk, iRST_N        : clock, asynchronous active-low reset
//   iNewGame/iHit/iStand: one-cycle control pulses
//   card_if (master)   : card handshake with the shuffler
//   pValue/dValue [4:0]: player / dealer hand values
//   currCard [5:0]     : last accepted card
//   gameOver, playerWon: round result (playerWon valid while gameOver=1)
//   state_o            : FSM state, for observation
// Parameter DEALER_STAND: dealer draws while its hand is below this value.
// Optional feature macro: BJ_SOFT_ACE_EN (soft aces, handled in bj_hand).
module blackjack_game_ctrl
    import bj_pkg::*;
#(
    parameter int unsigned DEALER_STAND = 17
) (
    input  logic                  clk,
    input  logic                  iRST_N,
    input  logic                  iNewGame,
    input  logic                  iHit,
    input  logic                  iStand,
    blackjack_game_ctrl_if.master card_if,
    output logic [4:0]            pValue,
    output logic [4:0]            dValue,
    output logic [5:0]            currCard,
    output logic                  gameOver,
    output logic                  playerWon,
    output bj_state_e             state_o
);

    bj_state_e  state_q, state_d;
    bj_who_e    who_q, who_d;
    logic [1:0] dealCnt_q, dealCnt_d;   // 0..2 opening deal, 3 = deal finished
    logic       playerWon_d;
    logic       playerWon_q, gameOver_q, oCardReq_q;
    logic [5:0] currCard_q;
    logic       clear_hands, accept;
    logic [3:0] rank;

    assign rank = card_if.iCard[5:2];
    // iNewGame aborts a draw in progress, so a card on that same edge is dropped.
    assign accept = oCardReq_q && card_if.iCardValid && (rank_value(rank) != 4'd0) && !iNewGame;

    always_comb begin
        state_d     = state_q;
        who_d       = who_q;
        dealCnt_d   = dealCnt_q;
        playerWon_d = playerWon_q;
        clear_hands = 1'b0;
        if (iNewGame) begin
            state_d     = ST_DRAW;
            who_d       = WHO_PLAYER;
            dealCnt_d   = 2'd0;
            playerWon_d = 1'b0;
            clear_hands = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: ;
                ST_DRAW: if (accept) state_d = ST_EVAL;
                ST_EVAL: begin
                    if (dealCnt_q < 2'd2) begin
                        // Opening deal alternates player, dealer, player.
                        dealCnt_d = dealCnt_q + 2'd1;
                        who_d     = (who_q == WHO_PLAYER) ? WHO_DEALER : WHO_PLAYER;
                        state_d   = ST_DRAW;
                    end else if (dealCnt_q == 2'd2) begin
                        dealCnt_d = 2'd3;
                        state_d   = ST_PLAYER;
                    end else if (who_q == WHO_PLAYER) begin
                        if (pValue > BJ_BUST) begin
                            state_d     = ST_DONE;
                            playerWon_d = 1'b0;
                        end else begin
                            state_d = ST_PLAYER;
                        end
                    end else begin
                        state_d = ST_DEALER;
                    end
                end
                ST_PLAYER: begin
                    if (iStand) begin
                        state_d = ST_DEALER;
                    end else if (iHit) begin
                        who_d   = WHO_PLAYER;
                        state_d = ST_DRAW;
                    end
                end
                ST_DEALER: begin
                    if (dValue < 5'(DEALER_STAND)) begin
                        who_d   = WHO_DEALER;
                        state_d = ST_DRAW;
                    end else begin
                        state_d     = ST_DONE;
                        // Tie goes to the dealer.
                        playerWon_d = (dValue > BJ_BUST) || (pValue > dValue);
                    end
                end
                ST_DONE: ;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge iRST_N) begin
        if (!iRST_N) begin
            state_q     <= ST_IDLE;
            who_q       <= WHO_PLAYER;
            dealCnt_q   <= 2'd0;
            playerWon_q <= 1'b0;
            gameOver_q  <= 1'b0;
            oCardReq_q  <= 1'b0;
            currCard_q  <= '0;
        end else begin
            state_q     <= state_d;
            who_q       <= who_d;
            dealCnt_q   <= dealCnt_d;
            playerWon_q <= playerWon_d;
            gameOver_q  <= (state_d == ST_DONE);
            oCardReq_q  <= (state_d == ST_DRAW);
            if (accept) currCard_q <= card_if.iCard;
        end
    end

    bj_hand u_player (
        .clk    (clk),
        .iRST_N (iRST_N),
        .clear  (clear_hands),
        .add    (accept && who_q == WHO_PLAYER),
        .rank   (rank),
        .value  (pValue)
    );

    bj_hand u_dealer (
        .clk    (clk),
        .iRST_N (iRST_N),
        .clear  (clear_hands),
        .add    (accept && who_q == WHO_DEALER),
        .rank   (rank),
        .value  (dValue)
    );

    assign card_if.oCardReq = oCardReq_q;
    assign currCard         = currCard_q;
    assign gameOver         = gameOver_q;
    assign playerWon        = playerWon_q;
    assign state_o          = state_q;

endmodule

// File: tb/tb_blackjack_game_ctrl.sv
// tb_blackjack_game_ctrl: directed bench for blackjack_game_ctrl with a
// card-list hand model and a per-cycle compare process.
module tb_blackjack_game_ctrl;
    import bj_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic iRST_N;
    always #5 clk = ~clk;

    logic       iNewGame, iHit, iStand;
    logic [4:0] pValue, dValue;
    logic [5:0] currCard;
    logic       gameOver, playerWon;
    bj_state_e  state_o;

    blackjack_game_ctrl_if card_if ();

    blackjack_game_ctrl dut (
        .clk       (clk),
        .iRST_N    (iRST_N),
        .iNewGame  (iNewGame),
        .iHit      (iHit),
        .iStand    (iStand),
        .card_if   (card_if),
        .pValue    (pValue),
        .dValue    (dValue),
        .currCard  (currCard),
        .gameOver  (gameOver),
        .playerWon (playerWon),
        .state_o   (state_o)
    );

    // ---------------- scoreboard / model ----------------
    int n_total = 0;
    int n_pass  = 0;

    int         m_p_sum, m_d_sum;
    bit         m_p_ace, m_d_ace;
    logic [5:0] m_curr;
    bit         m_over, m_won;
    bit         over_known;
    bit         cmp_en;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    function automatic int card_val(input logic [5:0] c);
        int r;
        r = int'(c[5:2]);
        if (r == 0)                 return 1;
        else if (r >= 2 && r <= 9)  return r;
        else if (r >= 12)           return 10;
        else                        return 0;
    endfunction

    function automatic logic [4:0] hand_val(input int sum, input bit ace);
        int s;
        s = (sum > 31) ? 31 : sum;
`ifdef BJ_SOFT_ACE_EN
        if (ace && s <= 11) s = s + 10;
`else
        if (ace) s = s + 0;
`endif
        return 5'(s);
    endfunction

    function automatic bit model_won();
        int p, d;
        p = int'(hand_val(m_p_sum, m_p_ace));
        d = int'(hand_val(m_d_sum, m_d_ace));
        if (p > 21) return 1'b0;
        return (d > 21) || (p > d);
    endfunction

    task automatic model_add(input bit to_dealer, input logic [5:0] c);
        int v;
        v = card_val(c);
        if (to_dealer) begin
            m_d_sum += v;
            if (v == 1) m_d_ace = 1'b1;
        end else begin
            m_p_sum += v;
            if (v == 1) m_p_ace = 1'b1;
        end
        m_curr = c;
    endtask

    task automatic model_clear_hands();
        m_p_sum = 0; m_d_sum = 0; m_p_ace = 0; m_d_ace = 0;
        m_over = 0; m_won = 0;
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("cyc_pValue", pValue, hand_val(m_p_sum, m_p_ace));
            chk("cyc_dValue", dValue, hand_val(m_d_sum, m_d_ace));
            chk("cyc_currCard", currCard, m_curr);
            if (over_known) begin
                chk("cyc_gameOver", gameOver, m_over);
                if (m_over) chk("cyc_playerWon", playerWon, m_won);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic new_game();
        iNewGame = 1'b1;
        tick();
        iNewGame = 1'b0;
        model_clear_hands();
        over_known = 1'b1;
        chk("newgame_req", card_if.oCardReq, 1'b1);
        chk("newgame_gameOver", gameOver, 1'b0);
    endtask

    task automatic give_card(input bit to_dealer, input logic [5:0] c);
        int n;
        n = 0;
        while (card_if.oCardReq !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        if (n >= 20) begin
            n_total++;
            $display("FAIL card_req_timeout: oCardReq=%0d, expected 1", card_if.oCardReq);
        end else begin
            card_if.iCard      = c;
            card_if.iCardValid = 1'b1;
            tick();
            card_if.iCardValid = 1'b0;
            model_add(to_dealer, c);
            chk("req_low_after_accept", card_if.oCardReq, 1'b0);
        end
    endtask

    task automatic deal3(input logic [5:0] p1, input logic [5:0] d1, input logic [5:0] p2);
        give_card(1'b0, p1);
        give_card(1'b1, d1);
        give_card(1'b0, p2);
    endtask

    task automatic hit(input logic [5:0] c);
        tick(); tick();
        iHit = 1'b1;
        tick();
        iHit = 1'b0;
        give_card(1'b0, c);
    endtask

    task automatic stand();
        tick(); tick();
        iStand = 1'b1;
        tick();
        iStand = 1'b0;
    endtask

    task automatic expect_over(input bit won_lit);
        int n;
        bit w;
        over_known = 1'b0;
        n = 0;
        while (gameOver !== 1'b1 && n < 10) begin
            tick();
            n++;
        end
        w = model_won();
        chk("over_gameOver", gameOver, 1'b1);
        chk("over_playerWon_model", playerWon, w);
        chk("over_playerWon_lit", playerWon, won_lit);
        m_over = 1'b1;
        m_won  = w;
        over_known = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("done_no_req", card_if.oCardReq, 1'b0);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        iRST_N = 1'b0; iNewGame = 0; iHit = 0; iStand = 0;
        card_if.iCard = '0; card_if.iCardValid = 1'b0;
        cmp_en = 0; over_known = 0;
        model_clear_hands();
        m_curr = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_pValue", pValue, 5'd0);
        chk("rst_dValue", dValue, 5'd0);
        chk("rst_currCard", currCard, 6'd0);
        chk("rst_gameOver", gameOver, 1'b0);
        chk("rst_playerWon", playerWon, 1'b0);
        chk("rst_req", card_if.oCardReq, 1'b0);
        chk("rst_state", state_o, ST_IDLE);
        iRST_N = 1'b1;
        tick();
        cmp_en = 1'b1;
        over_known = 1'b1;

        // Reset mid-DRAW
        new_game();
        #2 iRST_N = 1'b0;
        model_clear_hands();
        m_curr = '0;
        #1;
        chk("midrst_req", card_if.oCardReq, 1'b0);
        chk("midrst_state", state_o, ST_IDLE);
        chk("midrst_pValue", pValue, 5'd0);
        #3 iRST_N = 1'b1;
        card_if.iCard = 6'b110000;
        card_if.iCardValid = 1'b1;
        repeat (3) tick();
        card_if.iCardValid = 1'b0;
        chk("postrst_currCard", currCard, 6'd0);
        chk("postrst_state", state_o, ST_IDLE);
        chk("postrst_req", card_if.oCardReq, 1'b0);

        // Deal and stand: 10, 7, 9; dealer draws 10
        new_game();
        deal3(6'b110000, 6'b011100, 6'b100100);
        stand();
        give_card(1'b1, 6'b110001);
        expect_over(1'b1);
        chk("ds_pValue_lit", pValue, 5'd19);
        chk("ds_dValue_lit", dValue, 5'd17);

        // Invalid card discard, then a draw aborted by iNewGame
        new_game();
        card_if.iCard = 6'b101000;
        card_if.iCardValid = 1'b1;
        tick();
        chk("inv_req", card_if.oCardReq, 1'b1);
        chk("inv_currCard", currCard, 6'b110001);
        card_if.iCard = 6'b001100;
        tick();
        card_if.iCardValid = 1'b0;
        model_add(1'b0, 6'b001100);
        chk("inv_next_currCard", currCard, 6'b001100);
        chk("inv_next_pValue", pValue, 5'd3);
        tick();
        card_if.iCard = 6'b110000;
        card_if.iCardValid = 1'b1;
        iNewGame = 1'b1;
        tick();
        iNewGame = 1'b0;
        card_if.iCardValid = 1'b0;
        model_clear_hands();
        chk("abort_dValue", dValue, 5'd0);
        chk("abort_pValue", pValue, 5'd0);
        chk("abort_req", card_if.oCardReq, 1'b1);

        // Player bust: 10, 5, 6 then K
        deal3(6'b110000, 6'b010100, 6'b011000);
        chk("bust_pre_pValue", pValue, 5'd16);
        hit(6'b111100);
        expect_over(1'b0);
        chk("bust_pValue_lit", pValue, 5'd26);

        // Ace: A, 9, 5 then hit 6; dealer 9+10 stands on 19
        new_game();
        deal3(6'b000000, 6'b100100, 6'b010100);
`ifdef BJ_SOFT_ACE_EN
        chk("ace_soft_pValue", pValue, 5'd16);
`else
        chk("ace_hard_pValue", pValue, 5'd6);
`endif
        hit(6'b011000);
        chk("ace_hit_pValue", pValue, 5'd12);
        stand();
        give_card(1'b1, 6'b110100);
        expect_over(1'b0);

        // Tie 18/18 (iStand during DRAW must be ignored), then iNewGame in DONE
        new_game();
        iStand = 1'b1;
        tick();
        iStand = 1'b0;
        chk("stand_ignored_req", card_if.oCardReq, 1'b1);
        deal3(6'b110000, 6'b100000, 6'b100001);
        stand();
        give_card(1'b1, 6'b110100);
        expect_over(1'b0);
        chk("tie_dValue_lit", dValue, 5'd18);
        new_game();
        chk("tie_newgame_gameOver", gameOver, 1'b0);
        chk("tie_newgame_playerWon", playerWon, 1'b0);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/blackjack_game_ctrl.md
# blackjack_game_ctrl

Game controller for the DE2 blackjack design, directly upstream of the LCD display stage. It requests cards from the shuffler over a valid/request handshake, accumulates player and dealer hand values, and runs the deal/hit/stand/dealer-draw sequence. It drives the score, current-card and result signals consumed by the display.

## Interface
- DEALER_STAND, 17, dealer draws while its hand value is below this.
- clk  in  1  system clock
- iRST_N  in  1  **reset iRST_N, asynchronous, active-low; clock clk**
- iNewGame  in  1  one-cycle pulse (debounced upstream); start a new round
- iHit  in  1  one-cycle pulse; player takes a card
- iStand  in  1  one-cycle pulse; player ends turn
- iCard  in  6  card from shuffler; [5:2] rank code, [1:0] suit
- iCardValid  in  1  iCard valid this cycle
- oCardReq  out  1  controller wants a card
- pValue  out  5  player hand value
- dValue  out  5  dealer hand value
- currCard  out  6  last accepted card
- gameOver  out  1  round finished
- playerWon  out  1  player won (meaningful only when gameOver=1)

## Operation
- Rank codes:
  - 0000 = Ace, value 1.
  - 0010..1001 = 2..9.
  - 1100 = 10; 1101 = J, 1110 = Q, 1111 = K, each value 10.
  - 0001, 1010, 1011 are invalid. An invalid card is discarded: it is not added to either hand, currCard is unchanged, and oCardReq stays high.
- States: IDLE, DRAW, EVAL, PLAYER, DEALER, DONE. Register `who` (player/dealer) selects the target hand. Register `dealCnt` (0..3) sequences the opening deal.
- IDLE: waits for iNewGame. iNewGame clears both hands and sets dealCnt=0, then goes to DRAW.
- Opening deal order is player, dealer, player. The dealer's second card is drawn in the DEALER phase.
- DRAW:
  - oCardReq=1.
  - On a cycle with iCardValid=1 and a valid rank: add the card to the `who` hand, load currCard, go to EVAL.
- EVAL, while dealing: if dealCnt<2, increment dealCnt, update `who`, go to DRAW; otherwise go to PLAYER.
- EVAL, after a hit: if pValue>21, go to DONE with playerWon=0; otherwise go to PLAYER.
- PLAYER:
  - iStand goes to DEALER.
  - iHit sets who=player and goes to DRAW.
  - If both are high in the same cycle, iStand wins.
- DEALER:
  - If dValue<DEALER_STAND: set who=dealer and go to DRAW. The following EVAL returns to DEALER.
  - Otherwise go to DONE.
  - playerWon = (dValue>21) || (pValue>dValue). A tie is a dealer win.
- DONE: gameOver=1, outputs hold until iNewGame.
- iNewGame is honoured in every state, overrides iHit/iStand, and aborts any pending draw.
- iHit/iStand are ignored outside PLAYER.
- Hand value width is 5 bits. The hard total is the sum of card values, saturating at 31.

## Timing
- Reset values of all outputs are 0, and the state is IDLE.
- Card accepted at cycle N:
  - Hand value and currCard are updated at N+1 (registered).
  - oCardReq is low at N+1 (state EVAL).
- oCardReq is a registered function of state. Cards presented while oCardReq=0 are ignored.
- Bust and winner decisions are registered. gameOver and playerWon rise together in the first DONE cycle.
- iNewGame at cycle N:
  - pValue=dValue=0, gameOver=0, playerWon=0 at N+1.
  - oCardReq=1 at N+1.
  - currCard keeps its last value.

## Configuration
- BJ_SOFT_ACE_EN defined:
  - Each hand tracks an ace flag.
  - Value = hard + 10 when the flag is set and hard ≤ 11; otherwise value = hard.
  - The dealer stands on soft totals at or above DEALER_STAND.
- BJ_SOFT_ACE_EN undefined: an Ace always counts 1, and value = hard.

## Structure
- Package bj_pkg holds:
  - the state enum;
  - rank-code constants (RANK_ACE, RANK_TEN, RANK_KING, etc.);
  - BJ_BUST = 21;
  - a rank-to-value function returning 4 bits, with invalid ranks flagged.
- Sub-module bj_hand, instantiated once for the player and once for the dealer:
  - inputs: clk, iRST_N, clear, add, rank;
  - state: hard-total register (saturating) and ace flag;
  - output: 5-bit value, with soft-ace logic under the macro.

## Test plan
- Reset mid-DRAW: assert iRST_N low while oCardReq=1 → all outputs 0 immediately and the state is IDLE; a card presented afterwards is ignored.
- Deal and stand: iNewGame; cards 10♠ (110000), 7 (011100), 9 (100100); then iStand; dealer receives 10 → pValue=19, dValue=17, gameOver=1, playerWon=1.
- Player bust: deal 10, 5, 6 (pValue=16); iHit with a K → pValue=26, gameOver=1, playerWon=0, and no further oCardReq.
- Invalid card discard: iCard rank 1010 with iCardValid=1 → currCard unchanged, oCardReq stays 1; the next valid 3 is accepted one cycle after it is presented.
- Soft ace (macro defined): deal A, 9, 5 → pValue=16. Player hits a 6 → pValue=12. Macro undefined: same sequence → 6, then 12.
- Tie: pValue=18, dValue=18 after the dealer stands → gameOver=1, playerWon=0. iNewGame during DONE → gameOver=0 the next cycle.
